// File: rtl/inst_loader_pkg.sv
// Shared types and framing constants for the instruction-memory program loader.
package inst_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

  localparam int HEADER_BYTES   = 4;
  localparam int BYTES_PER_WORD = 4;

  // True when a 32-bit word index addresses a location inside a 2^width deep memory.
  function automatic logic idx_in_depth(input logic [31:0] idx, input int width);
    return (idx >> width) == 32'd0;
  endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects four bytes into a big-endian 32-bit word; used for both the header and the payload.
module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_reg;
  logic [23:0] shift_reg;

  // The 4th byte completes the word in the same cycle it arrives.
  assign word_valid = byte_valid && (cnt_reg == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift_reg, byte_in};

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (clear) begin
      cnt_reg   <= 2'd0;
    end else if (byte_valid) begin
      cnt_reg   <= cnt_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_in};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Frames a length-prefixed byte stream into instruction-memory writes with start/end pulses.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 15
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      we,
  output logic [INST_MEM_WIDTH-1:0] waddr,
  output logic [31:0]               wdata,
  output logic                      input_start,
  output logic                      input_end,
  output logic                      loading,
  output logic                      overflow,
  output logic [31:0]               word_count
);

  loader_state_t             state_reg;
  logic [31:0]               word_idx_reg;
  logic [31:0]               word_count_reg;
  logic                      we_reg;
  logic [INST_MEM_WIDTH-1:0] waddr_reg;
  logic [31:0]               wdata_reg;
  logic                      input_start_reg;
  logic                      input_end_reg;
  logic                      loading_reg;
  logic                      overflow_reg;

  logic        asm_clear;
  logic        asm_byte_valid;
  logic        asm_valid;
  logic [31:0] asm_word;

  // Bytes arriving during FINISH are dropped and the assembler is realigned for the next frame.
  assign asm_clear      = (state_reg == FINISH);
  assign asm_byte_valid = rx_valid && (state_reg != FINISH);

  byte_assembler u_asm (
    .CLK        (CLK),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_byte_valid),
    .byte_in    (rx_data),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg       <= IDLE;
      word_idx_reg    <= 32'd0;
      word_count_reg  <= 32'd0;
      we_reg          <= 1'b0;
      waddr_reg       <= '0;
      wdata_reg       <= 32'd0;
      input_start_reg <= 1'b0;
      input_end_reg   <= 1'b0;
      loading_reg     <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      we_reg          <= 1'b0;
      input_start_reg <= 1'b0;
      input_end_reg   <= 1'b0;
      // A new start in the input_end cycle overrides this clear below.
      if (input_end_reg) begin
        loading_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (rx_valid) begin
            input_start_reg <= 1'b1;
            loading_reg     <= 1'b1;
            overflow_reg    <= 1'b0;
            state_reg       <= HEADER;
          end
        end
        HEADER: begin
          if (asm_valid) begin
            word_count_reg <= asm_word;
            word_idx_reg   <= 32'd0;
            state_reg      <= (asm_word == 32'd0) ? FINISH : DATA;
          end
        end
        DATA: begin
          if (asm_valid) begin
            if (idx_in_depth(word_idx_reg, INST_MEM_WIDTH)) begin
              we_reg    <= 1'b1;
              waddr_reg <= word_idx_reg[INST_MEM_WIDTH-1:0];
              wdata_reg <= asm_word;
            end else begin
              overflow_reg <= 1'b1;
            end
            if (word_idx_reg == word_count_reg - 32'd1) begin
              state_reg <= FINISH;
            end else begin
              word_idx_reg <= word_idx_reg + 32'd1;
            end
          end
        end
        FINISH: begin
          input_end_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign we          = we_reg;
  assign waddr       = waddr_reg;
  assign wdata       = wdata_reg;
  assign input_start = input_start_reg;
  assign input_end   = input_end_reg;
  assign loading     = loading_reg;
  assign overflow    = overflow_reg;
  assign word_count  = word_count_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Drives framed byte streams into two loader instances (deep and 4-word memory) and checks every cycle.
module tb_inst_loader;

  localparam int MAXC = 4096;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;

  logic        we0, we1;
  logic [14:0] waddr0;
  logic [1:0]  waddr1;
  logic [31:0] wdata0, wdata1;
  logic        start0, start1, end0, end1, load0, load1, ovf0, ovf1;
  logic [31:0] wc0, wc1;

  always #5 CLK = ~CLK;

  inst_loader #(.INST_MEM_WIDTH(15)) u_dut (
    .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .we(we0), .waddr(waddr0), .wdata(wdata0), .input_start(start0), .input_end(end0),
    .loading(load0), .overflow(ovf0), .word_count(wc0));

  inst_loader #(.INST_MEM_WIDTH(2)) u_small (
    .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .we(we1), .waddr(waddr1), .wdata(wdata1), .input_start(start1), .input_end(end1),
    .loading(load1), .overflow(ovf1), .word_count(wc1));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int dep [2] = '{32768, 4};

  // Time-stamped expected events, indexed by the cycle in which the output should show them.
  bit          ev_rst    [MAXC];
  bit          ev_start  [MAXC];
  bit          ev_end    [MAXC];
  bit          ev_wc_set [MAXC];
  logic [31:0] ev_wc     [MAXC];
  bit          ev_we     [2][MAXC];
  bit          ev_ovf    [2][MAXC];
  int          ev_addr   [2][MAXC];
  logic [31:0] ev_data   [2][MAXC];

  logic [31:0] fw [16];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  // Reference model: applies scheduled events and compares all outputs once per cycle.
  initial begin
    bit          m_load;
    logic [31:0] m_wc;
    bit          m_ovf [2];
    int          m_wa  [2];
    logic [31:0] m_wd  [2];
    bit          m_we  [2];
    m_load = 0; m_wc = 0;
    for (int d = 0; d < 2; d++) begin m_ovf[d] = 0; m_wa[d] = 0; m_wd[d] = 0; end
    forever begin
      @(negedge CLK);
      if (cyc >= 1 && cyc < MAXC) begin
        if (ev_rst[cyc]) begin
          m_load = 0; m_wc = 0;
          for (int d = 0; d < 2; d++) begin m_ovf[d] = 0; m_wa[d] = 0; m_wd[d] = 0; end
        end
        if (ev_start[cyc]) begin m_load = 1; m_ovf[0] = 0; m_ovf[1] = 0; end
        if (ev_wc_set[cyc]) m_wc = ev_wc[cyc];
        for (int d = 0; d < 2; d++) begin
          m_we[d] = ev_we[d][cyc];
          if (ev_ovf[d][cyc]) m_ovf[d] = 1;
          if (ev_we[d][cyc]) begin m_wa[d] = ev_addr[d][cyc]; m_wd[d] = ev_data[d][cyc]; end
        end
        check("we",          {31'd0, we0},    {31'd0, m_we[0]});
        check("waddr",       {17'd0, waddr0}, m_wa[0]);
        check("wdata",       wdata0,          m_wd[0]);
        check("input_start", {31'd0, start0}, {31'd0, ev_start[cyc]});
        check("input_end",   {31'd0, end0},   {31'd0, ev_end[cyc]});
        check("loading",     {31'd0, load0},  {31'd0, m_load});
        check("overflow",    {31'd0, ovf0},   {31'd0, m_ovf[0]});
        check("word_count",  wc0,             m_wc);
        check("s_we",        {31'd0, we1},    {31'd0, m_we[1]});
        check("s_waddr",     {30'd0, waddr1}, m_wa[1]);
        check("s_wdata",     wdata1,          m_wd[1]);
        check("s_start",     {31'd0, start1}, {31'd0, ev_start[cyc]});
        check("s_end",       {31'd0, end1},   {31'd0, ev_end[cyc]});
        check("s_loading",   {31'd0, load1},  {31'd0, m_load});
        check("s_overflow",  {31'd0, ovf1},   {31'd0, m_ovf[1]});
        check("s_word_count", wc1,            m_wc);
        if (ev_end[cyc]) m_load = 0;
      end
    end
  end

  task automatic idle_cycle();
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  // Sends header n plus fw[0..n-1]; abort_at >= 0 replaces that byte with a reset pulse.
  task automatic send_frame(input int n, input int gap_min, input int gap_max,
                            input int abort_at, input bit stray);
    int          c;
    int          k;
    logic [31:0] v;
    logic [7:0]  b;
    for (int j = 0; j < 4 + 4 * n; j++) begin
      if (j > 0) repeat ($urandom_range(gap_max, gap_min)) idle_cycle();
      if (j == abort_at) begin
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        reset = 1'b1;
        ev_rst[cyc + 1] = 1; ev_rst[cyc + 2] = 1;
        $display("txn reset at cyc=%0d after %0d bytes", cyc, j);
        repeat (2) begin @(posedge CLK); #1; end
        reset = 1'b0;
        return;
      end
      v = (j < 4) ? n : fw[(j - 4) / 4];
      b = v[31 - 8 * (j % 4) -: 8];
      drive_byte(b);
      c = cyc;
      if (j == 0) ev_start[c + 1] = 1;
      if (j == 3) begin
        ev_wc_set[c + 1] = 1; ev_wc[c + 1] = n;
        if (n == 0) ev_end[c + 2] = 1;
      end
      if (j >= 4 && j % 4 == 3) begin
        k = (j - 4) / 4;
        for (int d = 0; d < 2; d++) begin
          if (k < dep[d]) begin
            ev_we[d][c + 1] = 1; ev_addr[d][c + 1] = k; ev_data[d][c + 1] = fw[k];
          end else begin
            ev_ovf[d][c + 1] = 1;
          end
        end
        if (k == n - 1) ev_end[c + 2] = 1;
      end
    end
    if (stray) drive_byte(8'($urandom));
    idle_cycle();
    repeat (2) idle_cycle();
    $display("txn frame n=%0d gaps=%0d..%0d stray=%0d done cyc=%0d", n, gap_min, gap_max, stray, cyc);
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) fw[i] = $urandom;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) ev_rst[i] = 1;
    repeat (2) idle_cycle();

    fw[0] = 32'h12345678; fw[1] = 32'h9ABCDEF0;
    send_frame(2, 0, 0, -1, 0);
    send_frame(2, 1, 5, -1, 0);
    send_frame(0, 0, 2, -1, 1);
    rand_words(1);
    send_frame(1, 0, 0, -1, 0);
    rand_words(6);
    send_frame(6, 0, 1, -1, 0);
    rand_words(2);
    send_frame(2, 0, 0, -1, 1);
    rand_words(3);
    send_frame(3, 0, 1, 6, 0);
    repeat (2) idle_cycle();
    rand_words(3);
    send_frame(3, 0, 0, -1, 0);
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(8, 0);
      rand_words(n);
      send_frame(n, 0, $urandom_range(3, 0), -1, 1'($urandom));
    end
    repeat (3) idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(MAXC * 10 - 20);
    n_fail++;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that writes the instruction memory from a byte stream (UART receiver side) before and between runs. It frames a length-prefixed program, assembles big-endian 32-bit words, drives the instruction-memory write port, and brackets the load with `input_start`/`input_end` pulses. The fetch stage consumes these pulses to gate `inst_enable`. It sits between the UART RX block and the instruction memory write port.

## Interface
- `INST_MEM_WIDTH`, default 15: instruction-memory address width; depth is 2^INST_MEM_WIDTH words.
- `CLK`, input, 1: clock; all state changes on posedge.
- `reset`, input, 1: reset, synchronous, active-high.
- `rx_valid`, input, 1: one-cycle strobe; `rx_data` is valid this cycle. The loader never backpressures.
- `rx_data`, input, 8: received byte.
- `we`, output, 1: instruction-memory write enable, one-cycle pulse.
- `waddr`, output, INST_MEM_WIDTH: write word address.
- `wdata`, output, 32: write data.
- `input_start`, output, 1: one-cycle pulse when a load begins.
- `input_end`, output, 1: one-cycle pulse when a load completes.
- `loading`, output, 1: high from the `input_start` cycle through the `input_end` cycle.
- `overflow`, output, 1: sticky; the program length exceeded memory depth. Cleared only by reset or by the next `input_start`.
- `word_count`, output, 32: header length N of the current or last load.

## Operation
- Frame format: a 4-byte header N (big-endian, unsigned), then N words of 4 bytes each, big-endian (first byte goes to bits 31:24).
- FSM states: IDLE, HEADER, DATA, FINISH.
- IDLE: the first `rx_valid` stores the byte as header byte 0, pulses `input_start`, clears `overflow`, and moves to HEADER.
- HEADER: collect header bytes 1–3. On the 4th byte, latch N into `word_count` and reset the word index to 0.
  - N = 0: go to FINISH.
  - Otherwise: go to DATA.
- DATA: assemble bytes.
  - On each 4th byte, write the word at `waddr` = word index, provided index < 2^INST_MEM_WIDTH.
  - Indexes at or beyond depth: suppress `we`, set `overflow`, but keep counting bytes so framing stays aligned.
  - After word N-1 is accepted, go to FINISH.
- FINISH: pulse `input_end` and return to IDLE. Any `rx_valid` in this cycle is dropped.
- Word index and N are 32-bit; the comparison index == N-1 is done at 32 bits. `waddr` is the low INST_MEM_WIDTH bits of the index.
- Reset mid-load: return to IDLE immediately, with no `input_end` pulse. Partially written memory is not restored.

## Timing
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `input_start`=0, `input_end`=0, `loading`=0, `overflow`=0, `word_count`=0. Byte counter and word index are 0; FSM is in IDLE.
- `input_start` is high in the cycle after the first header byte's `rx_valid`.
- `we`/`waddr`/`wdata` are registered: high the cycle after the `rx_valid` of a word's 4th byte. `wdata` and `waddr` hold their value until the next write.
- `input_end` is high the cycle after the last word's `we` cycle. With N=0, it is high the cycle after the `we`-equivalent slot, i.e. two cycles after the 4th header byte.
- Back-to-back `rx_valid` on every cycle must be sustained with no byte loss.
- `input_start` and `input_end` are never high in the same cycle.

## Structure
- Package `inst_loader_pkg`:
  - `loader_state_t` enum (IDLE, HEADER, DATA, FINISH).
  - `HEADER_BYTES` = 4.
  - `BYTES_PER_WORD` = 4.
- Sub-module `byte_assembler`:
  - 2-bit byte counter and 24-bit shift register.
  - Outputs `word_valid` and `word[31:0]` combinationally on the 4th byte.
  - Synchronous `clear` input.
  - Reused for the header and the data words.
- Top module: FSM, word index, write-port registers, pulse generation, overflow flag.

## Test plan
- Header 00 00 00 02, then words 12 34 56 78 and 9A BC DE F0, bytes sent every cycle:
  - `input_start` once.
  - `we` at addr 0 with 0x12345678, then `we` at addr 1 with 0x9ABCDEF0.
  - `input_end` the cycle after the second `we`; `word_count`=2.
- Same frame with 1–5 idle cycles between bytes: identical writes and pulses, and `loading` stays high throughout.
- Header N=0:
  - `input_start`, no `we`, then `input_end`.
  - A following second frame of N=1 writes addr 0 correctly.
- INST_MEM_WIDTH=2, N=6:
  - Writes happen at addrs 0–3 only.
  - `overflow`=1 from the 5th word onward.
  - `input_end` after the 6th word's bytes.
  - `overflow` is cleared by the next frame's `input_start`.
- Reset asserted after 2 data bytes of a 3-word frame:
  - All outputs return to reset values and there is no `input_end`.
  - A fresh frame loads from addr 0.
